// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tap sequencer.
//   - state_t      : sequencer FSM states
//   - DEF_*        : default geometry / widths
//   - acc_w_min()  : smallest accumulator width that cannot overflow over a
//                    full KxK window of signed x unsigned products
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_K      = 3;
    localparam int DEF_IMG_W  = 8;
    localparam int DEF_ADDR_W = 8;

    // One product is 2*dw+1 bits; summing k*k of them grows by clog2(k*k).
    function automatic int acc_w_min(input int dw, input int k);
        return 2 * dw + 1 + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_tap_sequencer_mac.sv
// tap_mac: signed weight x unsigned pixel multiply feeding an accumulator.
// Ports:
//   clk, rst  : clock, async active-high reset (accumulator -> 0)
//   i_clr     : synchronous clear, wins over i_en
//   i_en      : add the current product into the accumulator
//   i_wt      : signed weight, DATA_W bits
//   i_pix     : unsigned pixel, DATA_W bits
//   o_acc     : signed accumulator, ACC_W bits
module tap_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_wt,
    input  logic        [DATA_W-1:0] i_pix,
    output logic signed [ACC_W-1:0]  o_acc
);

    localparam int PROD_W = 2 * DATA_W + 1;

    logic signed [PROD_W-1:0] w_wt_x;
    logic signed [PROD_W-1:0] w_pix_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_x;

    // Both operands widened to the exact product width so the multiply is a
    // plain signed multiply; the pixel gets a zero sign bit.
    assign w_wt_x   = {{(DATA_W + 1){i_wt[DATA_W-1]}}, i_wt};
    assign w_pix_x  = {{(DATA_W + 1){1'b0}}, i_pix};
    assign w_prod   = w_wt_x * w_pix_x;
    assign w_prod_x = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_acc <= '0;
        end else if (i_clr) begin
            o_acc <= '0;
        end else if (i_en) begin
            o_acc <= o_acc + w_prod_x;
        end
    end

endmodule

// File: rtl/conv_tap_sequencer.sv
// conv_tap_sequencer: walks one KxK window through a multiply-accumulate,
// fetching pixels over req/ack and returning the sum over valid/ready.
// Ports:
//   clk, rst                   : clock, async active-high reset
//   wt_we, wt_addr, wt_data    : weight register file write (IDLE only)
//   start, base_addr           : window start pulse, top-left pixel address
//   busy                       : window in flight (start .. output handshake)
//   pix_req, pix_addr          : pixel fetch request, held until pix_ack
//   pix_ack, pix_data          : fetch complete, pixel valid this cycle
//   out_pix, out_valid, out_ready : result handshake
//   done                       : one-cycle pulse on the result handshake
// Build option: define CONV_TAP_RELU_EN to clamp negative results to 0.
module conv_tap_sequencer
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int K      = DEF_K,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ACC_W  = acc_w_min(DEF_DATA_W, DEF_K)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wt_we,
    input  logic [$clog2(K*K)-1:0]     wt_addr,
    input  logic signed [DATA_W-1:0]   wt_data,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    output logic                       busy,
    output logic                       pix_req,
    output logic [ADDR_W-1:0]          pix_addr,
    input  logic                       pix_ack,
    input  logic [DATA_W-1:0]          pix_data,
    output logic signed [ACC_W-1:0]    out_pix,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       done
);

    localparam int NTAPS = K * K;
    localparam int TAP_W = $clog2(NTAPS);
    localparam int RC_W  = $clog2(K + 1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);
    localparam logic [RC_W-1:0]  LAST_COL = RC_W'(K - 1);

    state_t r_state, w_next;

    logic [ADDR_W-1:0]        r_base;
    logic [RC_W-1:0]          r_row, r_col;
    logic [TAP_W-1:0]         r_tap;   // tracks row*K+col, the weight index
    logic                     r_gap;   // bubble cycle after each ack
    logic                     r_all;   // last tap has been accumulated
    logic signed [DATA_W-1:0] r_wt [NTAPS];

    logic                     w_start_ok;
    logic                     w_tap_en;
    logic signed [ACC_W-1:0]  w_acc;
    logic [ADDR_W-1:0]        w_row_off;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_tap_en   = (r_state == FETCH) && !r_gap && pix_ack;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            // Leave FETCH from the bubble after the final ack, which also
            // lets the last product land in the accumulator first.
            FETCH:   if (r_gap && r_all) w_next = OUT;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- tap walk ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_tap  <= '0;
            r_gap  <= 1'b0;
            r_all  <= 1'b0;
        end else if (w_start_ok) begin
            r_base <= base_addr;
            r_row  <= '0;
            r_col  <= '0;
            r_tap  <= '0;
            r_gap  <= 1'b0;
            r_all  <= 1'b0;
        end else if (w_tap_en) begin
            r_gap <= 1'b1;
            if (r_tap == LAST_TAP) begin
                r_all <= 1'b1;
            end else begin
                r_tap <= r_tap + 1'b1;
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end else if (r_state == FETCH && r_gap) begin
            r_gap <= 1'b0;
        end
    end

    // ---------------- weights ----------------
    // Writes only land in IDLE so a window always sees one frozen kernel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) r_wt[i] <= '0;
        end else if (wt_we && r_state == IDLE && wt_addr <= LAST_TAP) begin
            r_wt[wt_addr] <= wt_data;
        end
    end

    // ---------------- datapath ----------------
    tap_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start_ok),
        .i_en  (w_tap_en),
        .i_wt  (r_wt[r_tap]),
        .i_pix (pix_data),
        .o_acc (w_acc)
    );

    // All terms ADDR_W wide so the sum wraps modulo the buffer size.
    assign w_row_off = ADDR_W'(r_row) * ADDR_W'(IMG_W);
    assign pix_addr  = r_base + w_row_off + ADDR_W'(r_col);

    assign pix_req   = (r_state == FETCH) && !r_gap;
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == OUT);
    assign done      = out_valid && out_ready;

`ifdef CONV_TAP_RELU_EN
    assign out_pix = w_acc[ACC_W-1] ? '0 : w_acc;
`else
    assign out_pix = w_acc;
`endif

endmodule

// File: tb/tb_conv_tap_sequencer.sv
module tb_conv_tap_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               wt_we;
    logic [3:0]         wt_addr;
    logic signed [7:0]  wt_data;
    logic               start;
    logic [7:0]         base_addr;
    logic               busy;
    logic               pix_req;
    logic [7:0]         pix_addr;
    logic               pix_ack;
    logic [7:0]         pix_data;
    logic signed [20:0] out_pix;
    logic               out_valid;
    logic               out_ready;
    logic               done;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    bit         ack_tie = 1'b1;
    bit         pend    = 1'b0;
    int         wait_n  = 0;
    logic [7:0] held_addr;
    logic [7:0] addr_q [$];
    int         done_cnt = 0;

    always #5 clk = ~clk;

    conv_tap_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .wt_we     (wt_we),
        .wt_addr   (wt_addr),
        .wt_data   (wt_data),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .pix_req   (pix_req),
        .pix_addr  (pix_addr),
        .pix_ack   (pix_ack),
        .pix_data  (pix_data),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    // Pixel buffer model: either ack tied high, or ack after 0-3 wait cycles
    // with request stability checked while the fetch is outstanding.
    always @(negedge clk) begin
        if (ack_tie) begin
            pend     = 1'b0;
            pix_ack  = 1'b1;
            pix_data = mem[pix_addr];
        end else begin
            if (pix_ack) begin
                pix_ack = 1'b0;
                pend    = 1'b0;
                checks++;
                if (pix_req !== 1'b0) begin
                    errors++;
                    $display("FAIL req_gap: pix_req=%b after ack, want 0", pix_req);
                end
            end else if (pix_req) begin
                if (pend) begin
                    checks++;
                    if (pix_addr !== held_addr) begin
                        errors++;
                        $display("FAIL addr_stable: pix_addr=%0d want %0d", pix_addr, held_addr);
                    end
                end else begin
                    pend      = 1'b1;
                    held_addr = pix_addr;
                    wait_n    = $urandom_range(0, 3);
                end
                if (wait_n == 0) begin
                    pix_ack  = 1'b1;
                    pix_data = mem[pix_addr];
                end else begin
                    wait_n--;
                end
            end else if (pend) begin
                pend = 1'b0;
                checks++;
                errors++;
                $display("FAIL req_stable: pix_req dropped before ack, addr %0d", held_addr);
            end
        end
    end

    always @(posedge clk) begin
        if (pix_req && pix_ack) addr_q.push_back(pix_addr);
        if (done) done_cnt++;
    end

    task automatic fill_mem(input int mode);
        for (int a = 0; a < 256; a++) begin
            case (mode)
                0:       mem[a] = 8'd3;
                1:       mem[a] = 8'd255;
                default: mem[a] = 8'(a % 16);
            endcase
        end
    endtask

    task automatic load_wts(input int w0, input int step);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wt_we   = 1'b1;
            wt_addr = 4'(i);
            wt_data = 8'(w0 + step * i);
        end
        @(negedge clk);
        wt_we = 1'b0;
    endtask

    // Runs one window and completes the output handshake after 'hold'
    // cycles of back-pressure. Optional: weight write alongside start,
    // stray start pulses while busy, a weight write while busy.
    task automatic run_window(input logic [7:0] ba, input bit wr_now,
                              input int wa, input int wd, input bit stray,
                              input bit busy_wr, input int hold,
                              output logic signed [20:0] res, output int cyc);
        bit ok = 1'b0;
        int d0;
        addr_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        base_addr = ba;
        start     = 1'b1;
        if (wr_now) begin
            wt_we = 1'b1; wt_addr = 4'(wa); wt_data = 8'(wd);
        end
        @(posedge clk); #1;
        start = 1'b0;
        wt_we = 1'b0;
        cyc   = 1;
        for (int i = 0; i < 400; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            start     = stray && (i % 4 == 1);
            base_addr = stray ? 8'd100 : ba;
            wt_we     = busy_wr && (i == 5);
            wt_addr   = 4'(wa);
            wt_data   = 8'(wd);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        wt_we = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout: out_valid not seen, busy=%b", busy);
        end
        res = out_pix;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_pix !== res || done !== 1'b0) begin
                errors++;
                $display("FAIL out_hold: valid=%b pix=%0d done=%b want 1/%0d/0",
                         out_valid, out_pix, done, res);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%b want 1", done);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL post_hs: valid=%b busy=%b done=%b dones=%0d want 0/0/0/%0d",
                     out_valid, busy, done, done_cnt - d0, 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        start = 1'b0; base_addr = '0; out_ready = 1'b0;
        pix_ack = 1'b0; pix_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, pix_req, out_valid, done} !== 4'b0 || pix_addr !== 8'd0 || out_pix !== 21'sd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b req=%b valid=%b done=%b addr=%0d pix=%0d want all 0",
                     busy, pix_req, out_valid, done, pix_addr, out_pix);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic signed [20:0] r;
        int c;
        ack_tie = 1'b1;
        fill_mem(0);
        load_wts(5, 0);
        run_window(8'd0, 1'b0, 0, 0, 1'b0, 1'b0, 3, r, c);
        checks++;
        if (r !== 21'sd135) begin
            errors++;
            $display("FAIL basic_result: got %0d want 135", r);
        end
        checks++;
        if (c !== 19) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles want 19", c);
        end
    endtask

    task automatic test_negative();
        logic signed [20:0] r, exp;
        int c;
        ack_tie = 1'b1;
        fill_mem(1);
        load_wts(-1, -1);
`ifdef CONV_TAP_RELU_EN
        exp = 21'sd0;
`else
        exp = -21'sd11475;
`endif
        // out_ready raised before the result exists must not cause a done
        out_ready = 1'b1;
        run_window(8'd0, 1'b0, 0, 0, 1'b0, 1'b0, 0, r, c);
        checks++;
        if (r !== exp) begin
            errors++;
            $display("FAIL negative_result: got %0d want %0d", r, exp);
        end
    endtask

    task automatic test_wrap();
        logic signed [20:0] r;
        int c;
        logic [7:0] exp_a [9] = '{8'd250, 8'd251, 8'd252, 8'd2, 8'd3, 8'd4, 8'd10, 8'd11, 8'd12};
        ack_tie = 1'b1;
        run_window(8'd250, 1'b0, 0, 0, 1'b0, 1'b0, 0, r, c);
        checks++;
        if (addr_q.size() !== 9) begin
            errors++;
            $display("FAIL wrap_count: got %0d fetches want 9", addr_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (addr_q[i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d: got %0d want %0d", i, addr_q[i], exp_a[i]);
                end
            end
        end
    endtask

    // Weights -4..4 over pixels 0,1,2,8,9,10,0,1,2 (mem[a]=a%16, base 16):
    // -3 -4 -8 +10 +3 +8 = 6, identical with or without wait states.
    task automatic test_random_ack();
        logic signed [20:0] r;
        int c;
        fill_mem(2);
        load_wts(-4, 1);
        ack_tie = 1'b1;
        run_window(8'd16, 1'b0, 0, 0, 1'b0, 1'b0, 0, r, c);
        checks++;
        if (r !== 21'sd6) begin
            errors++;
            $display("FAIL zero_wait_result: got %0d want 6", r);
        end
        @(negedge clk);
        ack_tie = 1'b0;
        pix_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_window(8'd16, 1'b0, 0, 0, 1'b1, 1'b0, 1, r, c);
            checks++;
            if (r !== 21'sd6 || addr_q.size() !== 9) begin
                errors++;
                $display("FAIL random_ack_result: got %0d (%0d fetches) want 6 (9)", r, addr_q.size());
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL no_queue: busy=%b after window, want 0", busy);
            end
        end
        @(negedge clk);
        ack_tie = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic signed [20:0] r;
        int c, d0;
        bit hit = 1'b0;
        ack_tie = 1'b1;
        fill_mem(0);
        load_wts(5, 0);
        addr_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        base_addr = 8'd0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (addr_q.size() == 3 && pix_req) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!hit || {busy, pix_req, out_valid, done} !== 4'b0 || pix_addr !== 8'd0 || out_pix !== 21'sd0) begin
            errors++;
            $display("FAIL reset_mid: reached=%b busy=%b req=%b valid=%b addr=%0d pix=%0d want 1/0/0/0/0/0",
                     hit, busy, pix_req, out_valid, pix_addr, out_pix);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d busy=%b want 0/0", done_cnt - d0, busy);
        end
        load_wts(5, 0);
        run_window(8'd0, 1'b0, 0, 0, 1'b0, 1'b0, 0, r, c);
        checks++;
        if (r !== 21'sd135) begin
            errors++;
            $display("FAIL after_abort_result: got %0d want 135", r);
        end
    endtask

    task automatic test_wt_busy();
        logic signed [20:0] r;
        int c;
        ack_tie = 1'b1;
        fill_mem(0);
        load_wts(5, 0);
        run_window(8'd0, 1'b0, 4, 10, 1'b0, 1'b1, 0, r, c);
        checks++;
        if (r !== 21'sd135) begin
            errors++;
            $display("FAIL wt_busy_dropped: got %0d want 135", r);
        end
        // tap 4 becomes 10 in the same cycle as start: 8*15 + 30 = 150
        run_window(8'd0, 1'b1, 4, 10, 1'b0, 1'b0, 0, r, c);
        checks++;
        if (r !== 21'sd150) begin
            errors++;
            $display("FAIL wt_with_start: got %0d want 150", r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_wrap();
        test_random_ack();
        test_reset_mid();
        test_wt_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
